// File: rtl/column_mac_accum.sv
// ---------------------------------------------------------------------------
// column_mac_accum
//
// Matrix-vector multiply stage that sits behind the column selector. A job
// starts with the vector x being latched. Each accepted column k (LANES
// signed elements) is scaled by x[k]. The products are summed into LANES
// accumulators. After NCOL columns the pipeline drains, and y = M*x is then
// presented until the consumer acknowledges it.
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous, active-high reset
//   i_start         begin a job (sampled only while idle)
//   i_vec_in        vector x, element k at [k*DW +: DW]
//   i_col_in        current column, lane i at [i*DW +: DW]
//   i_col_valid     i_col_in holds a valid column
//   o_col_ready     stage accepts a column this cycle
//   o_result        y, lane i at [i*ACCW +: ACCW], signed
//   o_result_valid  result stable and valid
//   i_result_ack    consumer took the result
//   o_busy          a job is in progress or its result is pending
// ---------------------------------------------------------------------------
module column_mac_accum #(
    parameter int LANES = 16,
    parameter int DW    = 16,
    parameter int NCOL  = 16,
    parameter int ACCW  = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [NCOL*DW-1:0]      i_vec_in,
    input  logic [LANES*DW-1:0]     i_col_in,
    input  logic                    i_col_valid,
    output logic                    o_col_ready,
    output logic [LANES*ACCW-1:0]   o_result,
    output logic                    o_result_valid,
    input  logic                    i_result_ack,
    output logic                    o_busy
);

    localparam int KW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int PW = 2 * DW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [KW-1:0]          r_k;
    logic                   r_drain;
    logic                   r_result_valid;

    logic signed [DW-1:0]   r_x      [NCOL];
    logic signed [PW-1:0]   r_prod_p1[LANES];
    logic                   r_vld_p1;
    logic signed [ACCW-1:0] r_acc_p2 [LANES];

    logic                   w_launch;
    logic                   w_xfer;
    logic                   w_last;

    // Full-precision signed product. Both operands are widened first so the
    // multiply is done at product width; the exact result always fits.
    function automatic logic signed [PW-1:0] mul_full(
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b
    );
        logic signed [PW-1:0] ea;
        logic signed [PW-1:0] eb;
        ea = {{DW{a[DW-1]}}, a};
        eb = {{DW{b[DW-1]}}, b};
        return ea * eb;
    endfunction

    function automatic logic signed [ACCW-1:0] sext_prod(
        input logic signed [PW-1:0] p
    );
        return {{(ACCW-PW){p[PW-1]}}, p};
    endfunction

    assign w_launch    = (r_state == S_IDLE) && i_start;
    assign w_xfer      = (r_state == S_ACCUM) && i_col_valid;
    assign w_last      = (r_k == KW'(NCOL - 1));
    assign o_col_ready = (r_state == S_ACCUM);
    assign o_busy      = (r_state != S_IDLE);
    assign o_result_valid = r_result_valid;

    // Control: job sequencing, column index and result-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_k            <= '0;
            r_drain        <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_ACCUM;
                        r_k     <= '0;
                    end
                end
                S_ACCUM: begin
                    if (i_col_valid) begin
                        r_k <= r_k + KW'(1);
                        if (w_last) begin
                            r_state <= S_DRAIN;
                            r_drain <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Two cycles: one for the final product to be added in,
                    // one more so DONE coincides with a settled result.
                    if (r_drain) begin
                        r_state        <= S_DONE;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                S_DONE: begin
                    // A start arriving with the ack is dropped; it is only
                    // seen once the stage is back in IDLE.
                    if (i_result_ack) begin
                        r_state        <= S_IDLE;
                        r_result_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    // Stage p1: product of the accepted column with x[k].
    // Stage p2: accumulation of the previous cycle's products.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_prod_p1[i] <= '0;
                r_acc_p2[i]  <= '0;
            end
            for (int k = 0; k < NCOL; k++) begin
                r_x[k] <= '0;
            end
        end else begin
            r_vld_p1 <= w_xfer;
            if (w_xfer) begin
                for (int i = 0; i < LANES; i++) begin
                    r_prod_p1[i] <= mul_full(i_col_in[i*DW +: DW], r_x[r_k]);
                end
            end
            if (w_launch) begin
                for (int k = 0; k < NCOL; k++) begin
                    r_x[k] <= i_vec_in[k*DW +: DW];
                end
                for (int i = 0; i < LANES; i++) begin
                    r_acc_p2[i] <= '0;
                end
            end else if (r_vld_p1) begin
                for (int i = 0; i < LANES; i++) begin
                    r_acc_p2[i] <= r_acc_p2[i] + sext_prod(r_prod_p1[i]);
                end
            end
        end
    end

    // The result is a direct view of the accumulators.
    always_comb begin
        o_result = '0;
        for (int i = 0; i < LANES; i++) begin
            o_result[i*ACCW +: ACCW] = r_acc_p2[i];
        end
    end

endmodule

// File: tb/tb_column_mac_accum.sv
module tb_column_mac_accum;

    localparam int LANES = 16;
    localparam int DW    = 16;
    localparam int NCOL  = 16;
    localparam int ACCW  = 40;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  i_start;
    logic [NCOL*DW-1:0]    i_vec_in;
    logic [LANES*DW-1:0]   i_col_in;
    logic                  i_col_valid;
    logic                  o_col_ready;
    logic [LANES*ACCW-1:0] o_result;
    logic                  o_result_valid;
    logic                  i_result_ack;
    logic                  o_busy;

    column_mac_accum #(.LANES(LANES), .DW(DW), .NCOL(NCOL), .ACCW(ACCW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_vec_in(i_vec_in),
        .i_col_in(i_col_in), .i_col_valid(i_col_valid), .o_col_ready(o_col_ready),
        .o_result(o_result), .o_result_valid(o_result_valid),
        .i_result_ack(i_result_ack), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     mat [NCOL][LANES];
    int     xv  [NCOL];
    longint exp_y [LANES];
    bit     feed_ok;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint lane_out(input int i);
        logic signed [ACCW-1:0] t;
        t = o_result[i*ACCW +: ACCW];
        return longint'(t);
    endfunction

    function automatic int rnd16();
        logic signed [DW-1:0] t;
        t = DW'($urandom);
        return int'(t);
    endfunction

    // Reference: y_i = sum over k of M[k][i] * x[k], in plain integers.
    task automatic compute_model();
        for (int i = 0; i < LANES; i++) exp_y[i] = 0;
        for (int k = 0; k < NCOL; k++)
            for (int i = 0; i < LANES; i++)
                exp_y[i] += longint'(mat[k][i]) * longint'(xv[k]);
    endtask

    task automatic randomize_job();
        for (int k = 0; k < NCOL; k++) begin
            xv[k] = rnd16();
            for (int i = 0; i < LANES; i++) mat[k][i] = rnd16();
        end
    endtask

    task automatic load_start();
        for (int k = 0; k < NCOL; k++) i_vec_in[k*DW +: DW] = xv[k][DW-1:0];
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_vec_in = NCOL*DW'($urandom);
    endtask

    // Offer columns until NCOL transfers happen. Optional random gaps and an
    // optional start pulse on a given cycle (spulse < 0: none).
    task automatic feed(input bit stall, input int spulse);
        int  k;
        int  cyc;
        bit  v;
        bit  rdy;
        k = 0;
        cyc = 0;
        while (k < NCOL && cyc < 2000) begin
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            i_col_valid = v;
            if (v) begin
                for (int i = 0; i < LANES; i++) i_col_in[i*DW +: DW] = mat[k][i][DW-1:0];
            end else begin
                i_col_in = LANES*DW'($urandom);
            end
            i_start = (cyc == spulse);
            rdy = o_col_ready;
            step();
            if (v && rdy) k++;
            cyc++;
        end
        i_col_valid = 1'b0;
        i_start = 1'b0;
        feed_ok = (k == NCOL);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!o_result_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic ack_result();
        i_result_ack = 1'b1;
        step();
        i_result_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if ({o_busy, o_col_ready, o_result_valid} !== 3'b000 || o_result !== '0)
            $display("FAIL reset_state: busy/ready/valid=%b result_nz=%0d required 000/0",
                     {o_busy, o_col_ready, o_result_valid}, (o_result != '0));
        else n_pass++;

        randomize_job();
        load_start();
        i_col_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < LANES; i++) i_col_in[i*DW +: DW] = mat[k][i][DW-1:0];
            step();
        end
        i_col_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({o_busy, o_col_ready, o_result_valid} !== 3'b000 || o_result !== '0)
            $display("FAIL reset_mid_job: busy/ready/valid=%b result_nz=%0d required 000/0",
                     {o_busy, o_col_ready, o_result_valid}, (o_result != '0));
        else n_pass++;

        begin
            int n;
            randomize_job();
            compute_model();
            load_start();
            feed(1'b0, -1);
            wait_valid(n);
            n_checks++;
            if (!feed_ok || !o_result_valid)
                $display("FAIL reset_fresh_job_done: feed_ok=%0d valid=%0d required 1/1", feed_ok, o_result_valid);
            else n_pass++;
            for (int i = 0; i < LANES; i++) begin
                n_checks++;
                if (lane_out(i) !== exp_y[i])
                    $display("FAIL reset_fresh_y[%0d]: got %0d expected %0d", i, lane_out(i), exp_y[i]);
                else n_pass++;
            end
            ack_result();
        end
    endtask

    task automatic test_identity();
        for (int k = 0; k < NCOL; k++) begin
            xv[k] = 1;
            for (int i = 0; i < LANES; i++) mat[k][i] = k + 1;
        end
        load_start();
        feed(1'b0, -1);
        n_checks++;
        if (!feed_ok || o_col_ready !== 1'b0 || o_result_valid !== 1'b0)
            $display("FAIL ident_after_last: feed_ok=%0d ready=%b valid=%b required 1/0/0",
                     feed_ok, o_col_ready, o_result_valid);
        else n_pass++;
        step();
        n_checks++;
        if (o_result_valid !== 1'b0)
            $display("FAIL ident_latency_early: valid=%b one edge after last transfer, required 0", o_result_valid);
        else n_pass++;
        step();
        n_checks++;
        if (o_result_valid !== 1'b1)
            $display("FAIL ident_latency: valid=%b two edges after last transfer, required 1", o_result_valid);
        else n_pass++;
        for (int i = 0; i < LANES; i++) begin
            n_checks++;
            if (lane_out(i) !== 64'sd136)
                $display("FAIL ident_y[%0d]: got %0d expected 136", i, lane_out(i));
            else n_pass++;
        end
        ack_result();
        n_checks++;
        if (o_result_valid !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL ident_ack: valid=%b busy=%b required 0/0", o_result_valid, o_busy);
        else n_pass++;
    endtask

    task automatic test_sign_extreme();
        int n;
        for (int k = 0; k < NCOL; k++) begin
            xv[k] = -32768;
            for (int i = 0; i < LANES; i++) mat[k][i] = -32768;
        end
        load_start();
        feed(1'b0, -1);
        wait_valid(n);
        for (int i = 0; i < LANES; i++) begin
            n_checks++;
            if (lane_out(i) !== 64'sd17179869184)
                $display("FAIL extreme_y[%0d]: got %0d expected 17179869184", i, lane_out(i));
            else n_pass++;
        end
        ack_result();

        for (int k = 0; k < NCOL; k++) begin
            xv[k] = (k == 0) ? -1 : rnd16();
            for (int i = 0; i < LANES; i++) mat[k][i] = (k == 0) ? 7 : 0;
        end
        load_start();
        feed(1'b0, -1);
        wait_valid(n);
        for (int i = 0; i < LANES; i++) begin
            n_checks++;
            if (lane_out(i) !== -64'sd7)
                $display("FAIL mixed_y[%0d]: got %0d expected -7", i, lane_out(i));
            else n_pass++;
        end
        ack_result();
    endtask

    task automatic test_stalls();
        int n;
        bit ready_seen;
        randomize_job();
        compute_model();
        for (int pass = 0; pass < 2; pass++) begin
            load_start();
            feed(pass == 1, -1);
            ready_seen = 1'b0;
            n = 0;
            while (!o_result_valid && n < 20) begin
                if (o_col_ready) ready_seen = 1'b1;
                step();
                n++;
            end
            for (int c = 0; c < 3; c++) begin
                if (o_col_ready) ready_seen = 1'b1;
                step();
            end
            n_checks++;
            if (!feed_ok || !o_result_valid || ready_seen)
                $display("FAIL stall_drain_done[%0d]: feed_ok=%0d valid=%0d ready_seen=%0d required 1/1/0",
                         pass, feed_ok, o_result_valid, ready_seen);
            else n_pass++;
            for (int i = 0; i < LANES; i++) begin
                n_checks++;
                if (lane_out(i) !== exp_y[i])
                    $display("FAIL stall_y[%0d][%0d]: got %0d expected %0d", pass, i, lane_out(i), exp_y[i]);
                else n_pass++;
            end
            ack_result();
        end
    endtask

    task automatic test_handshake();
        int n;
        bit stable;
        logic [LANES*ACCW-1:0] snap;
        randomize_job();
        compute_model();
        load_start();
        feed(1'b0, 3);
        wait_valid(n);
        snap = o_result;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (o_result_valid !== 1'b1 || o_result !== snap) stable = 1'b0;
        end
        n_checks++;
        if (!stable)
            $display("FAIL hold_no_ack: result/valid changed while waiting for ack, required stable");
        else n_pass++;
        for (int i = 0; i < LANES; i++) begin
            n_checks++;
            if (lane_out(i) !== exp_y[i])
                $display("FAIL accum_start_ignored_y[%0d]: got %0d expected %0d", i, lane_out(i), exp_y[i]);
            else n_pass++;
        end
        i_start = 1'b1;
        step();
        n_checks++;
        if (o_result_valid !== 1'b1 || o_busy !== 1'b1 || o_result !== snap)
            $display("FAIL done_start_ignored: valid=%b busy=%b required 1/1", o_result_valid, o_busy);
        else n_pass++;
        i_result_ack = 1'b1;
        step();
        i_result_ack = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_result_valid !== 1'b0)
            $display("FAIL start_ack_together: busy=%b valid=%b required 0/0", o_busy, o_result_valid);
        else n_pass++;
        randomize_job();
        compute_model();
        for (int k = 0; k < NCOL; k++) i_vec_in[k*DW +: DW] = xv[k][DW-1:0];
        step();
        i_start = 1'b0;
        n_checks++;
        if (o_busy !== 1'b1 || o_col_ready !== 1'b1 || o_result !== '0)
            $display("FAIL restart_next_cycle: busy=%b ready=%b result_nz=%0d required 1/1/0",
                     o_busy, o_col_ready, (o_result != '0));
        else n_pass++;
        feed(1'b1, -1);
        wait_valid(n);
        for (int i = 0; i < LANES; i++) begin
            n_checks++;
            if (lane_out(i) !== exp_y[i])
                $display("FAIL restart_y[%0d]: got %0d expected %0d", i, lane_out(i), exp_y[i]);
            else n_pass++;
        end
        ack_result();
    endtask

    // A behavioural column selector walks a flat 4096-bit matrix and
    // advances on each accepted column; finish rises with the 16th.
    task automatic test_selector();
        logic [NCOL*LANES*DW-1:0] mbits;
        int  idx;
        int  cyc;
        int  n;
        bit  fin;
        bit  rdy;
        for (int w = 0; w < NCOL*LANES*DW/32; w++) mbits[w*32 +: 32] = $urandom;
        for (int k = 0; k < NCOL; k++) begin
            xv[k] = rnd16();
            for (int i = 0; i < LANES; i++) begin
                logic signed [DW-1:0] e;
                e = mbits[(k*LANES + i)*DW +: DW];
                mat[k][i] = int'(e);
            end
        end
        compute_model();
        load_start();
        idx = 0;
        fin = 1'b0;
        cyc = 0;
        while (!fin && cyc < 200) begin
            i_col_valid = 1'b1;
            i_col_in = mbits[idx*LANES*DW +: LANES*DW];
            rdy = o_col_ready;
            step();
            if (rdy) begin
                idx++;
                if (idx == NCOL) fin = 1'b1;
            end
            cyc++;
        end
        i_col_valid = 1'b0;
        n_checks++;
        if (!fin || o_col_ready !== 1'b0)
            $display("FAIL selector_finish: finish=%0d ready=%b required 1/0", fin, o_col_ready);
        else n_pass++;
        wait_valid(n);
        for (int i = 0; i < LANES; i++) begin
            n_checks++;
            if (lane_out(i) !== exp_y[i])
                $display("FAIL selector_y[%0d]: got %0d expected %0d", i, lane_out(i), exp_y[i]);
            else n_pass++;
        end
        ack_result();
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_vec_in = '0;
        i_col_in = '0;
        i_col_valid = 1'b0;
        i_result_ack = 1'b0;
        #1;
        test_reset();
        test_identity();
        test_sign_extreme();
        test_stalls();
        test_handshake();
        test_selector();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
